lac_slot_scheduler: RTL

Phase sequencer and slot arbiter on the 4x fabric clock. It locks a 2-bit phase counter to the one-per-frame `strobe` produced by logic-accessible-clock recovery, then shares one 4x-rate downstream resource among four requesters. Each requester owns one phase of the 40 MHz frame; idle phases are given to other requesters in round-robin order. It sits between the LAC recovery logic and the cluster datapath that consumes one word per 4x cycle.

---
 rtl/lac_slot_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lac_slot_scheduler.sv
// Locks a 2-bit phase counter to the per-frame strobe from LAC recovery, then
// shares one 4x-rate datapath slot among four requesters (owner phase + round-robin spill).
module lac_slot_scheduler #(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  strobe,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            gnt,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    output logic [1:0]            phase,
    output logic                  locked,
    output logic                  frame_start,
    output logic [ERR_W-1:0]      lock_err_cnt
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned GOOD_W = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          rr_q, rr_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [1:0]          out_src_q;

    logic [DATA_W-1:0]   words [NREQ];
    logic [3:0]          gnt_c;
    logic [1:0]          win_c;
    logic                spill_hit_c;
    logic [1:0]          spill_idx_c;
    logic [1:0]          cand_c;
    logic                early_c;
    logic                miss_c;
    logic                err_inc_c;
    logic [GOOD_W-1:0]   good_inc_c;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign words[gi] = data_in[gi*DATA_W +: DATA_W];
    end

    // First requester at or after rr_q, modulo 4; descending loop so the nearest wins.
    always_comb begin
        spill_hit_c = 1'b0;
        spill_idx_c = rr_q;
        cand_c      = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_c = rr_q + 2'(k);
            if (req[cand_c]) begin
                spill_hit_c = 1'b1;
                spill_idx_c = cand_c;
            end
        end
    end

    // Lock FSM, phase sequencing, grant generation.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        phase_d    = strobe ? 2'd1 : phase_q + 2'd1;
        rr_d       = rr_q;
        err_d      = err_q;
        err_inc_c  = 1'b0;
        gnt_c      = 4'b0000;
        win_c      = 2'd0;
        early_c    = strobe & (phase_q != 2'd0);
        miss_c     = ~strobe & (phase_q == 2'd0);
        good_inc_c = good_q + GOOD_W'(1);

        case (state_q)
            ST_UNLOCKED: begin
                if (strobe) begin
                    state_d = ST_CHECK;
                    good_d  = GOOD_W'(1);
                end
            end
            ST_CHECK: begin
                if (early_c) begin
                    good_d = GOOD_W'(1);
                end else if (strobe) begin
                    good_d = good_inc_c;
                    if (good_inc_c == GOOD_W'(LOCK_COUNT)) begin
                        state_d = ST_LOCKED;
                    end
                end else if (miss_c) begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end
            end
            ST_LOCKED: begin
                if (early_c) begin
                    state_d   = ST_CHECK;
                    good_d    = GOOD_W'(1);
                    err_inc_c = 1'b1;
                end else if (miss_c) begin
                    state_d   = ST_UNLOCKED;
                    good_d    = '0;
                    err_inc_c = 1'b1;
                end else if (req[phase_q]) begin
                    win_c          = phase_q;
                    gnt_c[phase_q] = 1'b1;
                end else if (spill_hit_c) begin
                    win_c              = spill_idx_c;
                    gnt_c[spill_idx_c] = 1'b1;
                    rr_d               = spill_idx_c + 2'd1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                good_d  = '0;
            end
        endcase

        if (err_inc_c && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_UNLOCKED;
            good_q      <= '0;
            phase_q     <= 2'd0;
            rr_q        <= 2'd0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            phase_q     <= phase_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
            out_valid_q <= |gnt_c;
            if (|gnt_c) begin
                out_data_q <= words[win_c];
                out_src_q  <= win_c;
            end
        end
    end

    assign gnt          = gnt_c;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_src      = out_src_q;
    assign phase        = phase_q;
    assign locked       = (state_q == ST_LOCKED);
    assign frame_start  = (state_q == ST_LOCKED) && (phase_q == 2'd0);
    assign lock_err_cnt = err_q;

endmodule
